bcd_down_timer: RTL

//  Four-digit BCD MM:SS countdown timer for the electronic-clock lab designs; counts down where the clock digits count up.

---
 rtl/bcd_timer_pkg.sv | 21 ++
 rtl/bcd_down_digit.sv | 41 ++++
 rtl/bcd_down_timer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/bcd_timer_pkg.sv
// Shared definitions for the BCD MM:SS countdown timer: state encodings,
// per-digit limits and the load clamp helper.
package bcd_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [3:0] SEC_ONES_LIM = 4'd9;
  localparam logic [3:0] SEC_TENS_LIM = 4'd5;
  localparam logic [3:0] MIN_ONES_LIM = 4'd9;

  // Out-of-range load values saturate at the digit limit rather than wrapping.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] val, input logic [3:0] lim);
    return (val > lim) ? lim : val;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit with wrap-to-limit and a combinational borrow
// out, so a chain of these ripples a full borrow within one clock.
module bcd_down_digit #(
  parameter logic [3:0] LIMIT = 4'd9
) (
  input  logic       clk,
  input  logic       rst_h,
  input  logic       sub,
  input  logic       ld,
  input  logic [3:0] ld_val,
  input  logic       clr,
  output logic [3:0] q,
  output logic       borrow
);

  logic [3:0] q_q;
  logic [3:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = 4'd0;
    end else if (ld) begin
      q_d = ld_val;
    end else if (sub) begin
      q_d = (q_q == 4'd0) ? LIMIT : (q_q - 4'd1);
    end
  end

  always_ff @(posedge clk or posedge rst_h) begin
    if (rst_h) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q      = q_q;
  assign borrow = sub & (q_q == 4'd0);

endmodule

// File: rtl/bcd_down_timer.sv
// Four-digit BCD MM:SS countdown timer with start/pause/load/clear control.
// Optional completion alarm is built only when TIMER_ALARM_EN is defined.
module bcd_down_timer
  import bcd_timer_pkg::*;
#(
  parameter int MIN_TENS_LIMIT = 5,
  parameter int ALARM_TICKS    = 10
) (
  input  logic       clk,
  input  logic       rst_h,
  input  logic       tick,
  input  logic       start,
  input  logic       pause,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] ld_m1,
  input  logic [3:0] ld_m0,
  input  logic [3:0] ld_s1,
  input  logic [3:0] ld_s0,
  output logic [3:0] m1,
  output logic [3:0] m0,
  output logic [3:0] s1,
  output logic [3:0] s0,
  output logic       running,
  output logic       paused,
  output logic       done,
  output logic       alarm
);

  localparam logic [3:0] MIN_TENS_LIM = 4'(MIN_TENS_LIMIT);

  state_e state_q;
  state_e state_d;

  logic       count_zero;
  logic       count_one;
  logic       dec;
  logic       b_s0;
  logic       b_s1;
  logic       b_m0;
  logic       b_m1;
  logic [3:0] ld_m1_c;
  logic [3:0] ld_m0_c;
  logic [3:0] ld_s1_c;
  logic [3:0] ld_s0_c;

  assign ld_m1_c = bcd_clamp(ld_m1, MIN_TENS_LIM);
  assign ld_m0_c = bcd_clamp(ld_m0, MIN_ONES_LIM);
  assign ld_s1_c = bcd_clamp(ld_s1, SEC_TENS_LIM);
  assign ld_s0_c = bcd_clamp(ld_s0, SEC_ONES_LIM);

  assign count_zero = (m1 == 4'd0) && (m0 == 4'd0) && (s1 == 4'd0) && (s0 == 4'd0);
  // The only decrement that lands on 00:00 starts from 00:01.
  assign count_one  = (m1 == 4'd0) && (m0 == 4'd0) && (s1 == 4'd0) && (s0 == 4'd1);

  assign dec = (state_q == ST_RUN) && tick && !pause && !clr && !load;

  always_comb begin
    state_d = state_q;
    if (clr || load) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (start && !count_zero) state_d = ST_RUN;
        ST_RUN: begin
          if (pause) begin
            state_d = ST_PAUSE;
          end else if (tick && count_one) begin
            state_d = ST_DONE;
          end
        end
        ST_PAUSE: if (start && !pause) state_d = ST_RUN;
        ST_DONE:  state_d = ST_DONE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_h) begin
    if (rst_h) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  bcd_down_digit #(.LIMIT(SEC_ONES_LIM)) u_s0 (
    .clk(clk), .rst_h(rst_h), .sub(dec), .ld(load), .ld_val(ld_s0_c),
    .clr(clr), .q(s0), .borrow(b_s0)
  );

  bcd_down_digit #(.LIMIT(SEC_TENS_LIM)) u_s1 (
    .clk(clk), .rst_h(rst_h), .sub(b_s0), .ld(load), .ld_val(ld_s1_c),
    .clr(clr), .q(s1), .borrow(b_s1)
  );

  bcd_down_digit #(.LIMIT(MIN_ONES_LIM)) u_m0 (
    .clk(clk), .rst_h(rst_h), .sub(b_s1), .ld(load), .ld_val(ld_m0_c),
    .clr(clr), .q(m0), .borrow(b_m0)
  );

  bcd_down_digit #(.LIMIT(MIN_TENS_LIM)) u_m1 (
    .clk(clk), .rst_h(rst_h), .sub(b_m0), .ld(load), .ld_val(ld_m1_c),
    .clr(clr), .q(m1), .borrow(b_m1)
  );

  assign running = (state_q == ST_RUN);
  assign paused  = (state_q == ST_PAUSE);
  assign done    = (state_q == ST_DONE);

`ifdef TIMER_ALARM_EN
  localparam int ACNT_W = $clog2(ALARM_TICKS + 1);

  logic              alarm_q;
  logic              alarm_d;
  logic [ACNT_W-1:0] acnt_q;
  logic [ACNT_W-1:0] acnt_d;
  logic              enter_done;

  assign enter_done = (state_d == ST_DONE) && (state_q != ST_DONE);

  // The final counted tick forces the alarm low so it always ends quiet.
  always_comb begin
    alarm_d = alarm_q;
    acnt_d  = acnt_q;
    if (clr || load) begin
      alarm_d = 1'b0;
      acnt_d  = '0;
    end else if (enter_done) begin
      alarm_d = 1'b1;
      acnt_d  = '0;
    end else if ((state_q == ST_DONE) && tick && (acnt_q < ACNT_W'(ALARM_TICKS))) begin
      acnt_d  = acnt_q + 1'b1;
      alarm_d = (acnt_q == ACNT_W'(ALARM_TICKS - 1)) ? 1'b0 : !alarm_q;
    end
  end

  always_ff @(posedge clk or posedge rst_h) begin
    if (rst_h) begin
      alarm_q <= 1'b0;
      acnt_q  <= '0;
    end else begin
      alarm_q <= alarm_d;
      acnt_q  <= acnt_d;
    end
  end

  assign alarm = alarm_q;
`else
  assign alarm = 1'b0;
`endif

endmodule
